issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits.
REQ-002 Parameter SIZE, default 64: register-file depth; AW = $clog2(SIZE).
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before error.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr  input  2+3*AW  {opcode[1:0], dst, src1, src2} packed MSB-first.
REQ-008 instr_ready  output  1  instruction accepted on instr_valid & instr_ready.
REQ-009 ld_en / ld_addr / ld_data  input  1 / AW / WIDTH  external register-file write.
REQ-010 rd_addr  input  AW; rd_data  output  WIDTH  combinational register-file readback.
REQ-011 exe_enable  output  1  execution-unit enable.
REQ-012 exe_opcode  output  2  opcode: 10 add, 11 sub, 01 mul.
REQ-013 exe_src1, exe_src2  output  WIDTH  registered operands.
REQ-014 exe_dst_addr  output  AW  destination address.
REQ-015 exe_ready  input  1  result valid from execution unit.
REQ-016 exe_dst  input  WIDTH  result value.
REQ-017 done  output  1  one-cycle pulse per retired instruction.
REQ-018 err  output  1  sticky timeout flag.
REQ-019 err_clr  input  1  clears err, returns to IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, WB, ERR.
REQ-021 instr_ready SHALL equal 1 only in IDLE.
REQ-022 On accept in IDLE: latch opcode/dst/src1/src2; opcode 00 (NOP) -> WB with no write; otherwise -> ISSUE.
REQ-023 ISSUE (exactly 1 cycle): register regfile[src1] and regfile[src2] into exe_src1/exe_src2, then -> WAIT.
REQ-024 exe_enable SHALL be 1 in every WAIT cycle and 0 in all other states; exe_opcode, exe_src*, exe_dst_addr stay stable throughout WAIT.
REQ-025 WAIT: exe_ready sampled 1 -> capture exe_dst, -> WB; the wait counter resets on entry to WAIT and increments each WAIT cycle.
REQ-026 WAIT: counter reaches TIMEOUT with exe_ready 0 -> ERR; no regfile write.
REQ-027 WB (1 cycle): write captured result to regfile[latched dst] (skipped for NOP); done=1; -> IDLE.
REQ-028 ERR: err=1, exe_enable=0, instr_ready=0; err_clr -> IDLE next edge, err=0.
REQ-029 ld_en SHALL write only in IDLE; ignored in all other states.
REQ-030 ld_en and accept in the same IDLE cycle: load commits at that edge; ISSUE reads the new value.
REQ-031 dst equal to src1 or src2: operands are the pre-write values; the write lands in WB.
REQ-032 Minimum latency accept -> done: 4 cycles (IDLE, ISSUE, WAIT with exe_ready=1, WB).
REQ-033 Result width: exe_dst stored unmodified, WIDTH bits; no extension or saturation.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, exe_enable=0, done=0, err=0, exe_opcode=00, exe_src1/2=0, exe_dst_addr=0, counter=0.
REQ-035 Register-file contents SHALL be cleared to 0 by reset.
REQ-036 Reset mid-WAIT: exe_enable drops asynchronously; the in-flight result is discarded and a late exe_ready is ignored in IDLE.

Structure
REQ-037 Opcode constants (NOP, MUL, ADD, SUB) and state encodings SHALL live in a shared package.
REQ-038 The register file SHALL be one sub-module, regfile (1 write port, 3 combinational read ports).

Verification
REQ-039 Load r1=5, r2=3; issue ADD r3,r1,r2; exe_ready 2 cycles into WAIT with exe_dst=8 -> done once, rd r3 = 8.
REQ-040 Issue NOP -> done 2 cycles after accept, exe_enable never 1, regfile unchanged.
REQ-041 TIMEOUT=4, exe_ready held 0 -> ERR after 4 WAIT cycles, err=1, exe_enable=0; err_clr -> IDLE, instr_ready=1.
REQ-042 r4=7; issue SUB r4,r4,r4 -> exe_src1=exe_src2=7; exe_dst=0 -> r4=0.
REQ-043 ld_en r5=9 in the accept cycle of MUL r6,r5,r5 -> exe_src1=9; ld_en during WAIT -> no write.
REQ-044 rst_n low in WAIT -> exe_enable=0 at once; regfile all 0; exe_ready pulse after release -> no done, no write.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | issue_ctrl_pkg : opcode constants and FSM state encoding             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package issue_ctrl_pkg;

  localparam logic [1:0] C_OP_NOP = 2'b00;
  localparam logic [1:0] C_OP_MUL = 2'b01;
  localparam logic [1:0] C_OP_ADD = 2'b10;
  localparam logic [1:0] C_OP_SUB = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_ERR   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/issue_ctrl_if.sv
// +----------------------------------------------------------------------+
// | issue_ctrl_if : instruction, load/readback and execution-unit bus    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface issue_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2+3*AW-1:0]     instr;
  logic                  ld_en;
  logic [AW-1:0]         ld_addr;
  logic [WIDTH-1:0]      ld_data;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  exe_enable;
  logic [1:0]            exe_opcode;
  logic [WIDTH-1:0]      exe_src1;
  logic [WIDTH-1:0]      exe_src2;
  logic [AW-1:0]         exe_dst_addr;
  logic                  exe_ready;
  logic [WIDTH-1:0]      exe_dst;
  logic                  done;
  logic                  err;
  logic                  err_clr;

  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr,
           exe_ready, exe_dst, err_clr,
    input  instr_ready, rd_data, exe_enable, exe_opcode, exe_src1,
           exe_src2, exe_dst_addr, done, err
  );

  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr,
           exe_ready, exe_dst, err_clr,
    output instr_ready, rd_data, exe_enable, exe_opcode, exe_src1,
           exe_src2, exe_dst_addr, done, err
  );
endinterface

`default_nettype wire

// File: rtl/issue_ctrl_regfile.sv
// +----------------------------------------------------------------------+
// | issue_ctrl_regfile : 1 write / 3 combinational read register file    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module issue_ctrl_regfile #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 64,
  parameter int AW    = $clog2(SIZE)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [AW-1:0]    i_raddr0,
  input  wire logic [AW-1:0]    i_raddr1,
  input  wire logic [AW-1:0]    i_raddr2,
  output logic      [WIDTH-1:0] o_rdata0,
  output logic      [WIDTH-1:0] o_rdata1,
  output logic      [WIDTH-1:0] o_rdata2
);

  logic [WIDTH-1:0] r_mem [SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/issue_ctrl.sv
// +----------------------------------------------------------------------+
// | issue_ctrl : single-issue controller driving an external exe unit    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 64,
  parameter int TIMEOUT = 255
) (
  input wire logic    clk,
  input wire logic    rst_n,
  issue_ctrl_if.slave bus
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [AW-1:0]    r_dst;
  logic [AW-1:0]    r_src1;
  logic [AW-1:0]    r_src2;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_exe_op;
  logic [WIDTH-1:0] r_exe_src1;
  logic [WIDTH-1:0] r_exe_src2;
  logic [AW-1:0]    r_exe_dst_addr;

  logic             w_instr_ready;
  logic             w_exe_enable;
  logic             w_done;
  logic             w_err;
  logic [1:0]       w_opcode;
  logic             w_timeout;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  assign w_opcode  = bus.instr[2+3*AW-1 -: 2];
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // External loads only land in IDLE; WB owns the write port otherwise.
  assign w_we    = ((r_state == S_IDLE) && bus.ld_en) ||
                   ((r_state == S_WB) && (r_op != C_OP_NOP));
  assign w_waddr = (r_state == S_WB) ? r_dst    : bus.ld_addr;
  assign w_wdata = (r_state == S_WB) ? r_result : bus.ld_data;

  issue_ctrl_regfile #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr0 (r_src1),
    .i_raddr1 (r_src2),
    .i_raddr2 (bus.rd_addr),
    .o_rdata0 (w_rd1),
    .o_rdata1 (w_rd2),
    .o_rdata2 (bus.rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_instr_ready = 1'b0;
    w_exe_enable  = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_instr_ready = 1'b1;
        if (bus.instr_valid) begin
          w_next = (w_opcode == C_OP_NOP) ? S_WB : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        w_exe_enable = 1'b1;
        if (bus.exe_ready) begin
          w_next = S_WB;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_err = 1'b1;
        if (bus.err_clr) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= C_OP_NOP;
      r_dst          <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_exe_op       <= C_OP_NOP;
      r_exe_src1     <= '0;
      r_exe_src2     <= '0;
      r_exe_dst_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_op   <= w_opcode;
            r_dst  <= bus.instr[3*AW-1 -: AW];
            r_src1 <= bus.instr[2*AW-1 -: AW];
            r_src2 <= bus.instr[AW-1:0];
          end
        end
        S_ISSUE: begin
          // Operands are snapshotted here, so a dst==src hazard sees pre-write values.
          r_exe_op       <= r_op;
          r_exe_src1     <= w_rd1;
          r_exe_src2     <= w_rd2;
          r_exe_dst_addr <= r_dst;
          r_cnt          <= '0;
        end
        S_WAIT: begin
          if (bus.exe_ready) begin
            r_result <= bus.exe_dst;
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready  = w_instr_ready;
  assign bus.exe_enable   = w_exe_enable;
  assign bus.done         = w_done;
  assign bus.err          = w_err;
  assign bus.exe_opcode   = r_exe_op;
  assign bus.exe_src1     = r_exe_src1;
  assign bus.exe_src2     = r_exe_src2;
  assign bus.exe_dst_addr = r_exe_dst_addr;

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_issue_ctrl : scoreboard bench with a behavioural register model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SIZE    = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [AW-1:0]    d;
  } exe_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [WIDTH-1:0] model_rf [SIZE];
  exe_t             op_q[$];
  int               done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  issue_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  issue_ctrl #(
    .WIDTH   (WIDTH),
    .SIZE    (SIZE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected operands on each WAIT entry and expected done cycles on each done.
  initial begin : monitor
    exe_t cur;
    logic prev_en;
    cur     = '0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.exe_enable === 1'b1 && !prev_en) begin
        check("exe_pending", 64'(op_q.size() > 0), 64'(1));
        if (op_q.size() > 0) cur = op_q.pop_front();
      end
      if (bus.exe_enable === 1'b1)
        check("exe_operands",
              64'({bus.exe_opcode, bus.exe_src1, bus.exe_src2, bus.exe_dst_addr}), 64'(cur));
      prev_en = (bus.exe_enable === 1'b1);
      if (bus.done === 1'b1) begin
        check("done_pending", 64'(done_q.size() > 0), 64'(1));
        if (done_q.size() > 0) check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input logic [AW-1:0] a, input string name);
    bus.rd_addr = a;
    #1;
    check(name, 64'(bus.rd_data), 64'(model_rf[a]));
  endtask

  task automatic check_lit(input logic [AW-1:0] a, input logic [WIDTH-1:0] v, input string name);
    bus.rd_addr = a;
    #1;
    check(name, 64'(bus.rd_data), 64'(v));
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < SIZE; i++) check_rd(AW'(i), name);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_flags"}, 64'({bus.instr_ready, bus.exe_enable, bus.done, bus.err}), 64'(4'b1000));
    check({tag, "_exe_regs"},
          64'({bus.exe_opcode, bus.exe_src1, bus.exe_src2, bus.exe_dst_addr}), 64'(0));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(bus.instr_ready), 64'(1));
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [WIDTH-1:0] v);
    wait_ready("ready_before_load");
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = v;
    model_rf[a] = v;
    tick();
    bus.ld_en = 1'b0;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                           input logic [AW-1:0] s2, input int lat, input bit ld_same,
                           input logic [AW-1:0] la, input logic [WIDTH-1:0] lv, input bit wait_ld);
    logic [WIDTH-1:0] a, b, res;
    int acc, n;
    wait_ready("ready_before_issue");
    bus.instr_valid = 1'b1;
    bus.instr       = {op, d, s1, s2};
    if (ld_same) begin
      bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = lv;
      model_rf[la] = lv;
    end
    a = model_rf[s1];
    b = model_rf[s2];
    case (op)
      C_OP_ADD: res = a + b;
      C_OP_SUB: res = a - b;
      C_OP_MUL: res = a * b;
      default:  res = '0;
    endcase
    acc = cyc + 1;
    if (op == C_OP_NOP) begin
      done_q.push_back(acc);
    end else begin
      op_q.push_back('{op: op, a: a, b: b, d: d});
      done_q.push_back(acc + 2 + lat);
    end
    tick();
    bus.instr_valid = 1'b0;
    bus.ld_en       = 1'b0;
    if (op != C_OP_NOP) begin
      n = 0;
      while (bus.exe_enable !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check("exe_enable_seen", 64'(bus.exe_enable), 64'(1));
      for (int i = 0; i < lat; i++) begin
        if (wait_ld) begin
          bus.ld_en   = 1'b1;
          bus.ld_addr = AW'($urandom_range(0, SIZE - 1));
          bus.ld_data = WIDTH'($urandom);
        end
        tick();
      end
      bus.ld_en     = 1'b0;
      bus.exe_ready = 1'b1;
      bus.exe_dst   = res;
      tick();
      bus.exe_ready = 1'b0;
      bus.exe_dst   = WIDTH'($urandom);
      model_rf[d]   = res;
    end
    wait_ready("ready_after_done");
    check_rd(d, "rd_dst");
  endtask

  task automatic run_timeout(input logic [AW-1:0] d, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    int acc;
    wait_ready("ready_before_timeout");
    bus.instr_valid = 1'b1;
    bus.instr       = {C_OP_ADD, d, s1, s2};
    op_q.push_back('{op: C_OP_ADD, a: model_rf[s1], b: model_rf[s2], d: d});
    acc = cyc + 1;
    tick();
    bus.instr_valid = 1'b0;
    // WAIT spans cycles acc+1 .. acc+TIMEOUT; ERR follows.
    while (cyc < acc + TIMEOUT) tick();
    check("wait_last_cycle", 64'({bus.err, bus.exe_enable}), 64'(2'b01));
    tick();
    check("err_entered", 64'({bus.err, bus.exe_enable, bus.instr_ready}), 64'(3'b100));
    tick();
    tick();
    check("err_sticky", 64'({bus.err, bus.exe_enable}), 64'(2'b10));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_cleared", 64'({bus.err, bus.instr_ready}), 64'(2'b01));
    check_rd(d, "rd_after_timeout");
  endtask

  task automatic run_reset();
    int n = 0;
    wait_ready("ready_before_reset_issue");
    bus.instr_valid = 1'b1;
    bus.instr       = {C_OP_ADD, AW'(7), AW'(1), AW'(2)};
    op_q.push_back('{op: C_OP_ADD, a: model_rf[1], b: model_rf[2], d: AW'(7)});
    tick();
    bus.instr_valid = 1'b0;
    while (bus.exe_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("reset_wait_entered", 64'(bus.exe_enable), 64'(1));
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_exe_enable_async", 64'(bus.exe_enable), 64'(0));
    check_idle_outputs("reset_mid_wait");
    foreach (model_rf[i]) model_rf[i] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.exe_ready = 1'b1;
    bus.exe_dst   = 8'h5A;
    tick();
    bus.exe_ready = 1'b0;
    tick();
    tick();
    check("late_ready_ignored", 64'({bus.instr_ready, bus.done, bus.exe_enable}), 64'(3'b100));
    sweep("rf_after_reset");
  endtask

  initial begin : stimulus
    logic [1:0] rop;
    bus.instr_valid = 1'b0; bus.instr   = '0;
    bus.ld_en       = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.rd_addr     = '0;
    bus.exe_ready   = 1'b0; bus.exe_dst = '0;
    bus.err_clr     = 1'b0;
    foreach (model_rf[i]) model_rf[i] = '0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_outputs("after_reset");
    sweep("rf_reset");

    do_load(AW'(1), 8'd5);
    do_load(AW'(2), 8'd3);
    run_instr(C_OP_ADD, AW'(3), AW'(1), AW'(2), 2, 1'b0, '0, '0, 1'b0);
    check_lit(AW'(3), 8'd8, "add_r3");

    run_instr(C_OP_NOP, AW'(9), AW'(1), AW'(2), 0, 1'b0, '0, '0, 1'b0);
    check_lit(AW'(9), 8'd0, "nop_no_write");

    do_load(AW'(4), 8'd7);
    run_instr(C_OP_SUB, AW'(4), AW'(4), AW'(4), 0, 1'b0, '0, '0, 1'b0);
    check_lit(AW'(4), 8'd0, "sub_r4");

    run_instr(C_OP_MUL, AW'(6), AW'(5), AW'(5), 3, 1'b1, AW'(5), 8'd9, 1'b1);
    check_lit(AW'(6), 8'd81, "mul_r6");
    check_lit(AW'(5), 8'd9, "ld_in_wait_ignored");

    run_timeout(AW'(10), AW'(1), AW'(2));

    repeat (60) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(AW'($urandom_range(0, SIZE - 1)), WIDTH'($urandom));
      end else begin
        rop = 2'($urandom_range(0, 3));
        run_instr(rop, AW'($urandom_range(0, SIZE - 1)), AW'($urandom_range(0, SIZE - 1)),
                  AW'($urandom_range(0, SIZE - 1)), $urandom_range(0, TIMEOUT - 1),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, SIZE - 1)),
                  WIDTH'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    sweep("rf_after_random");

    run_reset();
    check("queues_drained", 64'(op_q.size() + done_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
